rr_mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit output channel among four requesters. It drives the select of a 4-to-1 word multiplexer over the packed 128-bit requester data bus and enforces a valid/ready handshake toward the consumer. Bursts are bounded by a programmable beat count, which guarantees fairness. It sits between the four word producers and the single downstream sink of the datapath.

---
 rtl/rr_mux_arbiter_pkg.sv | 38 +++
 rtl/rr_mux_arbiter_mux4to1.sv | 26 ++
 rtl/rr_mux_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg
// Shared definitions for the round-robin multiplexer arbiter: channel
// geometry, the arbiter state encoding and the round-robin search helper
// used both for a fresh grant and for same-edge handover between owners.
package rr_mux_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int WORD_W  = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } rr_pick_t;

   // Scans mask starting at index start, wrapping modulo NUM_REQ, and
   // returns the first set position together with a found flag.
   function automatic rr_pick_t rr_next(input logic [NUM_REQ-1:0] mask,
                                        input logic [SEL_W-1:0]   start);
      rr_pick_t         pick;
      logic [SEL_W-1:0] idx;
      pick = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = start + SEL_W'(i);
         if (!pick.found && mask[idx]) begin
            pick.found = 1'b1;
            pick.idx   = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4to1.sv
// Mux4to1
// Purely combinational word selector over a packed four-word bus.
// Ports:
//   Out  selected 32-bit word
//   In   packed 128-bit bus, word i at In[32*i+31:32*i]
//   Sel  encoded word index
module Mux4to1
   import rr_mux_arbiter_pkg::*;
(
   output logic [WORD_W-1:0]         Out,
   input  logic [NUM_REQ*WORD_W-1:0] In,
   input  logic [SEL_W-1:0]          Sel
);

   always_comb begin
      Out = In[WORD_W-1:0];
      case (Sel)
         2'd0: Out = In[1*WORD_W-1:0*WORD_W];
         2'd1: Out = In[2*WORD_W-1:1*WORD_W];
         2'd2: Out = In[3*WORD_W-1:2*WORD_W];
         2'd3: Out = In[4*WORD_W-1:3*WORD_W];
         default: Out = In[WORD_W-1:0];
      endcase
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// Round-robin arbiter sharing one 32-bit output channel among four
// requesters. Grants are bounded to MAX_BURST beats so that every active
// requester is served in turn; handover between owners is bubble-free.
// Ports:
//   Clk       rising-edge clock
//   Reset     asynchronous active-high reset
//   Req       per-requester request, held while a word is ready
//   In        packed requester words, word i at In[32*i+31:32*i]
//   OutReady  consumer accepts Out this cycle
//   Gnt       registered one-hot grant, zero while idle
//   Sel       registered encoded grant index, drives the word mux
//   Out       selected word (combinational from In and Sel)
//   OutValid  Out carries a valid beat
//   Beat      a beat transfers this cycle; owner advances its word
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        Req,
   input  logic [NUM_REQ*WORD_W-1:0] In,
   input  logic                      OutReady,
   output logic [NUM_REQ-1:0]        Gnt,
   output logic [SEL_W-1:0]          Sel,
   output logic [WORD_W-1:0]         Out,
   output logic                      OutValid,
   output logic                      Beat
);

   state_t           state;
   state_t           state_next;
   logic [NUM_REQ-1:0] gnt_next;
   logic [SEL_W-1:0] sel_next;
   logic [3:0]       beat_cnt;
   logic [3:0]       cnt_next;
   logic [SEL_W-1:0] last_sel;
   logic [SEL_W-1:0] last_next;
   logic [4:0]       cnt_inc;
   logic             burst_done;
   logic             grant_end;
   rr_pick_t         pick_idle;
   rr_pick_t         pick_handover;

   // The owner's request doubles as its valid: a withdrawn request simply
   // stops presenting beats.
   assign OutValid = (state == BUSY) && Req[Sel];
   assign Beat     = OutValid && OutReady;

   assign cnt_inc    = {1'b0, beat_cnt} + 5'd1;
   assign burst_done = Beat && (cnt_inc == 5'(MAX_BURST));
   assign grant_end  = burst_done || !Req[Sel];

   // Idle search starts just after the last owner. The handover search
   // masks the current owner (Gnt is its one-hot) so that anyone else
   // waiting wins before the owner is allowed a fresh burst.
   assign pick_idle     = rr_next(Req, last_sel + 2'd1);
   assign pick_handover = rr_next(Req & ~Gnt, Sel + 2'd1);

   Mux4to1 u_mux (
      .Out (Out),
      .In  (In),
      .Sel (Sel)
   );

   // Next-state logic: arbitration from IDLE, burst accounting and
   // same-edge re-arbitration at end of grant while BUSY.
   always_comb begin
      state_next = state;
      gnt_next   = Gnt;
      sel_next   = Sel;
      cnt_next   = beat_cnt;
      last_next  = last_sel;
      case (state)
         IDLE: begin
            if (pick_idle.found) begin
               sel_next   = pick_idle.idx;
               gnt_next   = NUM_REQ'(1) << pick_idle.idx;
               cnt_next   = 4'd0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (grant_end) begin
               last_next = Sel;
               cnt_next  = 4'd0;
               if (pick_handover.found) begin
                  sel_next = pick_handover.idx;
                  gnt_next = NUM_REQ'(1) << pick_handover.idx;
               end else if (!Req[Sel]) begin
                  gnt_next   = '0;
                  state_next = IDLE;
               end
            end else if (Beat) begin
               cnt_next = cnt_inc[3:0];
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
         end
      endcase
   end

   // State register; reset leaves last_sel at 3 so requester 0 wins first.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         Gnt      <= '0;
         Sel      <= '0;
         beat_cnt <= 4'd0;
         last_sel <= 2'd3;
      end else begin
         state    <= state_next;
         Gnt      <= gnt_next;
         Sel      <= sel_next;
         beat_cnt <= cnt_next;
         last_sel <= last_next;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
// Directed bench for rr_mux_arbiter. Two instances share all inputs: one
// with bursts of 4 beats and one with bursts of 2 for the fairness run.
module tb_rr_mux_arbiter;

   logic         Clk;
   logic         Reset;
   logic [3:0]   Req;
   logic [127:0] In;
   logic         OutReady;

   logic [3:0]   gnt4;
   logic [1:0]   sel4;
   logic [31:0]  out4;
   logic         valid4;
   logic         beat4;

   logic [3:0]   gnt2;
   logic [1:0]   sel2;
   logic [31:0]  out2;
   logic         valid2;
   logic         beat2;

   int compared;
   int mismatched;

   rr_mux_arbiter #(.MAX_BURST(4)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Req      (Req),
      .In       (In),
      .OutReady (OutReady),
      .Gnt      (gnt4),
      .Sel      (sel4),
      .Out      (out4),
      .OutValid (valid4),
      .Beat     (beat4)
   );

   rr_mux_arbiter #(.MAX_BURST(2)) dut2 (
      .Clk      (Clk),
      .Reset    (Reset),
      .Req      (Req),
      .In       (In),
      .OutReady (OutReady),
      .Gnt      (gnt2),
      .Sel      (sel2),
      .Out      (out2),
      .OutValid (valid2),
      .Beat     (beat2)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic ready);
      Req      = req;
      OutReady = ready;
   endtask

   task automatic applyReset();
      Reset    = 1'b1;
      Req      = 4'b0000;
      OutReady = 1'b0;
      #2;
      Reset    = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Directed sequence: reset, single requester, fairness, backpressure,
   // withdrawal and asynchronous reset mid-burst.
   initial begin
      int expIdx;
      compared   = 0;
      mismatched = 0;
      Reset      = 1'b1;
      Req        = 4'b0000;
      OutReady   = 1'b0;
      In         = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      #1;
      $display("[TB] reset state");
      checkOutput("reset_gnt", 32'(gnt4), 32'h0);
      checkOutput("reset_valid", 32'(valid4), 32'h0);
      checkOutput("reset_out", out4, 32'h1111_1111);
      checkOutput("reset_sel", 32'(sel4), 32'h0);

      tick();
      Reset = 1'b0;
      $display("[TB] single requester");
      applyStimulus(4'b0100, 1'b1);
      tick();
      checkOutput("single_gnt", 32'(gnt4), 32'h4);
      checkOutput("single_sel", 32'(sel4), 32'h2);
      checkOutput("single_valid", 32'(valid4), 32'h1);
      checkOutput("single_out", out4, 32'h3333_3333);
      checkOutput("single_beat0", 32'(beat4), 32'h1);
      for (int k = 1; k < 4; k++) begin
         tick();
         checkOutput("single_beat", 32'(beat4), 32'h1);
         checkOutput("single_cnt", 32'(dut.beat_cnt), 32'(k));
         checkOutput("single_gnt_hold", 32'(gnt4), 32'h4);
      end
      tick();
      checkOutput("single_regrant_gnt", 32'(gnt4), 32'h4);
      checkOutput("single_regrant_cnt", 32'(dut.beat_cnt), 32'h0);
      checkOutput("single_regrant_last", 32'(dut.last_sel), 32'h2);

      $display("[TB] all requesting, bursts of 2");
      applyReset();
      applyStimulus(4'b1111, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         expIdx = (i / 2) % 4;
         checkOutput("rr_sel", 32'(sel2), 32'(expIdx));
         checkOutput("rr_gnt", 32'(gnt2), 32'(1 << expIdx));
         checkOutput("rr_valid", 32'(valid2), 32'h1);
         checkOutput("rr_beat", 32'(beat2), 32'h1);
      end

      $display("[TB] backpressure");
      applyReset();
      applyStimulus(4'b0010, 1'b0);
      tick();
      checkOutput("bp_gnt", 32'(gnt4), 32'h2);
      checkOutput("bp_valid", 32'(valid4), 32'h1);
      checkOutput("bp_beat0", 32'(beat4), 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("bp_sel", 32'(sel4), 32'h1);
         checkOutput("bp_out", out4, 32'h2222_2222);
         checkOutput("bp_beat", 32'(beat4), 32'h0);
         checkOutput("bp_cnt", 32'(dut.beat_cnt), 32'h0);
      end
      OutReady = 1'b1;
      #1;
      checkOutput("bp_release_beat", 32'(beat4), 32'h1);
      tick();
      checkOutput("bp_release_cnt", 32'(dut.beat_cnt), 32'h1);

      $display("[TB] withdrawal");
      applyReset();
      applyStimulus(4'b1000, 1'b1);
      tick();
      checkOutput("wd_gnt3", 32'(gnt4), 32'h8);
      checkOutput("wd_out3", out4, 32'h4444_4444);
      checkOutput("wd_beat3", 32'(beat4), 32'h1);
      tick();
      checkOutput("wd_cnt", 32'(dut.beat_cnt), 32'h1);
      applyStimulus(4'b0001, 1'b1);
      #1;
      checkOutput("wd_valid_drop", 32'(valid4), 32'h0);
      checkOutput("wd_beat_drop", 32'(beat4), 32'h0);
      tick();
      checkOutput("wd_gnt0", 32'(gnt4), 32'h1);
      checkOutput("wd_sel0", 32'(sel4), 32'h0);
      checkOutput("wd_last", 32'(dut.last_sel), 32'h3);
      checkOutput("wd_out0", out4, 32'h1111_1111);

      $display("[TB] reset mid-burst");
      applyReset();
      applyStimulus(4'b0100, 1'b1);
      tick();
      tick();
      checkOutput("mid_beat2", 32'(beat4), 32'h1);
      checkOutput("mid_cnt", 32'(dut.beat_cnt), 32'h1);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("mid_gnt", 32'(gnt4), 32'h0);
      checkOutput("mid_valid", 32'(valid4), 32'h0);
      checkOutput("mid_beat", 32'(beat4), 32'h0);
      checkOutput("mid_out", out4, 32'h1111_1111);
      checkOutput("mid_last", 32'(dut.last_sel), 32'h3);
      Req   = 4'b0110;
      Reset = 1'b0;
      tick();
      checkOutput("mid_regrant_gnt", 32'(gnt4), 32'h2);
      checkOutput("mid_regrant_sel", 32'(sel4), 32'h1);
      checkOutput("mid_regrant_out", out4, 32'h2222_2222);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
